// File: rtl/lifo_arbiter.sv
// Round-robin arbiter sharing one LIFO between NUM_CLIENTS push/pop requesters.
// Keeps its own occupancy count so grants never overflow or underflow the LIFO.
module lifo_arbiter #(
    parameter int unsigned NUM_CLIENTS = 2,
    parameter int unsigned DWIDTH      = 16,
    parameter int unsigned AWIDTH      = 8
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    input  logic [NUM_CLIENTS-1:0]        req_i,
    input  logic [NUM_CLIENTS-1:0]        op_i,
    input  logic [NUM_CLIENTS*DWIDTH-1:0] wdata_i,
    output logic [NUM_CLIENTS-1:0]        gnt_o,
    output logic [NUM_CLIENTS-1:0]        rsp_valid_o,
    output logic [DWIDTH-1:0]             rsp_data_o,
    output logic                          lifo_wrreq_o,
    output logic [DWIDTH-1:0]             lifo_data_o,
    output logic                          lifo_rdreq_o,
    input  logic [DWIDTH-1:0]             lifo_q_i,
    output logic [AWIDTH:0]               usedw_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int unsigned PtrW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [AWIDTH:0] DepthC = {1'b1, {AWIDTH{1'b0}}};

    logic [AWIDTH:0]        count_q, count_d;
    logic [PtrW-1:0]        rr_q, rr_d;
    logic                   pend_q, pend_d;
    logic [PtrW-1:0]        pend_idx_q, pend_idx_d;

    logic [NUM_CLIENTS-1:0] eligible;
    logic                   gnt_any;
    logic [PtrW-1:0]        gnt_idx;
    logic                   gnt_pop;
    int unsigned            cand;

    // Reset gating keeps grants and LIFO strobes quiet while arst_i is held.
    always_comb begin
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            eligible[k] = !arst_i && req_i[k] &&
                          (op_i[k] ? (count_q != '0) : (count_q != DepthC));
        end
    end

    // First eligible client at or after the round-robin pointer, wrapping.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cand = (int'(rr_q) + i) % NUM_CLIENTS;
            if (!gnt_any && eligible[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = PtrW'(cand);
            end
        end
    end

    always_comb begin
        gnt_pop = gnt_any && op_i[gnt_idx];
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            gnt_o[k] = gnt_any && (gnt_idx == PtrW'(k));
        end
        lifo_wrreq_o = gnt_any && !op_i[gnt_idx];
        lifo_rdreq_o = gnt_pop;
        lifo_data_o  = lifo_wrreq_o ? wdata_i[gnt_idx*DWIDTH +: DWIDTH] : '0;
    end

    always_comb begin
        count_d    = count_q;
        rr_d       = rr_q;
        pend_d     = 1'b0;
        pend_idx_d = pend_idx_q;
        if (gnt_any) begin
            rr_d = PtrW'((int'(gnt_idx) + 1) % NUM_CLIENTS);
            if (gnt_pop) begin
                count_d    = count_q - 1'b1;
                pend_d     = 1'b1;
                pend_idx_d = gnt_idx;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            count_q    <= '0;
            rr_q       <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            count_q    <= count_d;
            rr_q       <= rr_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            rsp_valid_o[k] = pend_q && (pend_idx_q == PtrW'(k));
        end
        rsp_data_o = pend_q ? lifo_q_i : '0;
        usedw_o    = count_q;
        full_o     = (count_q == DepthC);
        empty_o    = (count_q == '0);
    end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Randomized bench for lifo_arbiter: a stack-based reference model checked every cycle,
// a behavioural LIFO on the q side, and directed scenarios with literal expectations.
module tb_lifo_arbiter;

    localparam int NC    = 2;
    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 2 ** AW;

    logic               clk_i = 1'b0;
    logic               arst_i;
    logic [NC-1:0]      req_i;
    logic [NC-1:0]      op_i;
    logic [NC*DW-1:0]   wdata_i;
    logic [NC-1:0]      gnt_o;
    logic [NC-1:0]      rsp_valid_o;
    logic [DW-1:0]      rsp_data_o;
    logic               lifo_wrreq_o;
    logic [DW-1:0]      lifo_data_o;
    logic               lifo_rdreq_o;
    logic [DW-1:0]      lifo_q_i;
    logic [AW:0]        usedw_o;
    logic               full_o;
    logic               empty_o;

    int total = 0;
    int bad   = 0;

    lifo_arbiter #(
        .NUM_CLIENTS(NC),
        .DWIDTH     (DW),
        .AWIDTH     (AW)
    ) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .req_i       (req_i),
        .op_i        (op_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .lifo_wrreq_o(lifo_wrreq_o),
        .lifo_data_o (lifo_data_o),
        .lifo_rdreq_o(lifo_rdreq_o),
        .lifo_q_i    (lifo_q_i),
        .usedw_o     (usedw_o),
        .full_o      (full_o),
        .empty_o     (empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Behavioural LIFO on the q side: q registered one cycle after rdreq.
    logic [DW-1:0] mem [DEPTH];
    int            sp;
    always @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sp       <= 0;
            lifo_q_i <= '0;
        end else if (lifo_wrreq_o) begin
            if (sp < DEPTH) begin
                mem[sp] <= lifo_data_o;
                sp      <= sp + 1;
            end
        end else if (lifo_rdreq_o) begin
            if (sp > 0) begin
                lifo_q_i <= mem[sp-1];
                sp       <= sp - 1;
            end
        end
    end

    // Reference model: a queue as the stack, round-robin search from the last winner.
    logic [DW-1:0] m_stack [$];
    int            m_rr = 0;
    bit            m_pend = 0;
    int            m_pidx = 0;
    logic [DW-1:0] m_pdata = '0;
    int            g, c;
    logic [NC-1:0] e_gnt, e_rspv;
    logic [DW-1:0] e_data, e_rspd;
    logic          e_wr, e_rd;

    always @(negedge clk_i) begin
        if (arst_i) begin
            check("rst gnt", 32'(gnt_o), 0);
            check("rst rspv", 32'(rsp_valid_o), 0);
            check("rst rspd", 32'(rsp_data_o), 0);
            check("rst wr", 32'(lifo_wrreq_o), 0);
            check("rst rd", 32'(lifo_rdreq_o), 0);
            check("rst usedw", 32'(usedw_o), 0);
            check("rst empty", 32'(empty_o), 1);
            check("rst full", 32'(full_o), 0);
            m_stack.delete();
            m_rr   = 0;
            m_pend = 0;
        end else begin
            g = -1;
            for (int i = 0; i < NC; i++) begin
                c = (m_rr + i) % NC;
                if (g < 0 && req_i[c] &&
                    (op_i[c] ? m_stack.size() > 0 : m_stack.size() < DEPTH)) g = c;
            end
            e_gnt  = '0;
            e_wr   = 1'b0;
            e_rd   = 1'b0;
            e_data = '0;
            if (g >= 0) begin
                e_gnt[g] = 1'b1;
                e_wr     = !op_i[g];
                e_rd     = op_i[g];
                if (e_wr) e_data = wdata_i[g*DW +: DW];
            end
            e_rspv = '0;
            e_rspd = '0;
            if (m_pend) begin
                e_rspv[m_pidx] = 1'b1;
                e_rspd         = m_pdata;
            end
            check("mdl gnt", 32'(gnt_o), 32'(e_gnt));
            check("mdl wr", 32'(lifo_wrreq_o), 32'(e_wr));
            check("mdl rd", 32'(lifo_rdreq_o), 32'(e_rd));
            check("mdl ldata", 32'(lifo_data_o), 32'(e_data));
            check("mdl rspv", 32'(rsp_valid_o), 32'(e_rspv));
            check("mdl rspd", 32'(rsp_data_o), 32'(e_rspd));
            check("mdl usedw", 32'(usedw_o), 32'(m_stack.size()));
            check("mdl full", 32'(full_o), 32'(m_stack.size() == DEPTH));
            check("mdl empty", 32'(empty_o), 32'(m_stack.size() == 0));
            check("mdl wr_rd_excl", 32'(lifo_wrreq_o && lifo_rdreq_o), 0);
            m_pend = 0;
            if (g >= 0) begin
                if (e_wr) begin
                    m_stack.push_back(e_data);
                end else begin
                    m_pdata = m_stack.pop_back();
                    m_pend  = 1;
                    m_pidx  = g;
                end
                m_rr = (g + 1) % NC;
            end
        end
    end

    logic [NC-1:0] s_gnt, s_rspv;
    logic [DW-1:0] s_rspd;
    logic [AW:0]   s_usedw;
    logic          s_wr, s_rd, s_full, s_empty;

    // Sample at the falling edge, then return 1 time unit after the next rising edge.
    task automatic tick();
        @(negedge clk_i);
        s_gnt   = gnt_o;
        s_rspv  = rsp_valid_o;
        s_rspd  = rsp_data_o;
        s_usedw = usedw_o;
        s_wr    = lifo_wrreq_o;
        s_rd    = lifo_rdreq_o;
        s_full  = full_o;
        s_empty = empty_o;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        arst_i  = 1'b1;
        req_i   = '0;
        op_i    = '0;
        wdata_i = '0;
        tick();
        check("reset usedw", 32'(s_usedw), 0);
        check("reset empty", 32'(s_empty), 1);
        check("reset full", 32'(s_full), 0);
        check("reset gnt", 32'(s_gnt), 0);
        check("reset rspv", 32'(s_rspv), 0);
        tick();
        arst_i = 1'b0;

        // 1: interleaved pushes then LIFO-order pops
        req_i   = 2'b11;
        op_i    = 2'b00;
        wdata_i = {16'h3333, 16'h1111};
        tick(); check("t1 gnt0", 32'(s_gnt), 32'h1);
        wdata_i[15:0] = 16'h2222;
        tick(); check("t1 gnt1", 32'(s_gnt), 32'h2);
        req_i[1] = 1'b0;
        tick(); check("t1 gnt2", 32'(s_gnt), 32'h1);
        req_i = 2'b00;
        tick(); check("t1 usedw", 32'(s_usedw), 3);
        req_i = 2'b10;
        op_i  = 2'b10;
        tick(); check("t1 pop0 gnt", 32'(s_gnt), 32'h2);
        tick(); check("t1 rsp0", 32'(s_rspd), 32'h2222); check("t1 rspv0", 32'(s_rspv), 32'h2);
        tick(); check("t1 rsp1", 32'(s_rspd), 32'h3333);
        req_i = 2'b00;
        tick(); check("t1 rsp2", 32'(s_rspd), 32'h1111); check("t1 empty", 32'(s_empty), 1);

        // 2: fill to full, blocked push, pop frees a slot
        req_i = 2'b01;
        op_i  = 2'b00;
        for (int i = 0; i < DEPTH; i++) begin
            wdata_i[15:0] = 16'(i);
            tick();
            check("t2 fill gnt", 32'(s_gnt), 32'h1);
        end
        tick();
        check("t2 full", 32'(s_full), 1);
        check("t2 blocked gnt", 32'(s_gnt), 0);
        check("t2 blocked wr", 32'(s_wr), 0);
        req_i = 2'b11;
        op_i  = 2'b10;
        tick(); check("t2 pop gnt", 32'(s_gnt), 32'h2);
        req_i[1] = 1'b0;
        tick();
        check("t2 push after pop", 32'(s_gnt), 32'h1);
        check("t2 usedw 255", 32'(s_usedw), 255);
        check("t2 rspd", 32'(s_rspd), 32'h00ff);
        req_i = 2'b00;
        tick(); check("t2 refull", 32'(s_full), 1);
        req_i = 2'b10;
        op_i  = 2'b10;
        for (int i = 0; i < DEPTH; i++) tick();
        req_i = 2'b00;
        tick(); tick();
        check("t2 drained", 32'(s_empty), 1);

        // 3: pops on empty wait; one push enables exactly one pop
        req_i = 2'b11;
        op_i  = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3 no gnt", 32'(s_gnt), 0);
            check("t3 no rd", 32'(s_rd), 0);
        end
        req_i = 2'b10;
        tick();
        req_i         = 2'b11;
        op_i          = 2'b10;
        wdata_i[15:0] = 16'hABCD;
        tick(); check("t3 push gnt", 32'(s_gnt), 32'h1);
        req_i[0] = 1'b0;
        tick(); check("t3 pop gnt", 32'(s_gnt), 32'h2);
        req_i = 2'b00;
        tick();
        check("t3 rspv", 32'(s_rspv), 32'h2);
        check("t3 rspd", 32'(s_rspd), 32'hABCD);

        // 4: strict alternation under contention
        req_i = 2'b11;
        op_i  = 2'b00;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t4 alternate", 32'(s_gnt), (i % 2 == 1) ? 32'h2 : 32'h1);
            check("t4 excl", 32'(s_wr && s_rd), 0);
            for (int k = 0; k < NC; k++) if (s_gnt[k]) wdata_i[k*DW +: DW] = 16'($urandom);
        end
        req_i = 2'b00;

        // 5: reset right after a pop grant
        req_i = 2'b01;
        op_i  = 2'b01;
        tick(); check("t5 pop gnt", 32'(s_gnt), 32'h1);
        req_i  = 2'b00;
        arst_i = 1'b1;
        tick();
        check("t5 rspv", 32'(s_rspv), 0);
        check("t5 usedw", 32'(s_usedw), 0);
        check("t5 empty", 32'(s_empty), 1);
        arst_i = 1'b0;
        req_i  = 2'b11;
        op_i   = 2'b00;
        tick(); check("t5 rr at c0", 32'(s_gnt), 32'h1);
        req_i = 2'b00;

        // 6: push/pop ping-pong around count 1
        req_i = 2'b11;
        op_i  = 2'b10;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("t6 usedw range", 32'(s_usedw <= DEPTH), 1);
            if (s_gnt[0]) wdata_i[15:0] = 16'($urandom);
        end
        req_i = 2'b00;
        tick();

        // 7: randomized traffic with handshake-respecting clients
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            for (int k = 0; k < NC; k++) begin
                if (s_gnt[k] || !req_i[k]) begin
                    if ($urandom_range(0, 99) < 60) begin
                        req_i[k]             = 1'b1;
                        op_i[k]              = ($urandom_range(0, 99) <
                                                (((cyc / 600) % 2 == 0) ? 15 : 85));
                        wdata_i[k*DW +: DW]  = 16'($urandom);
                    end else begin
                        req_i[k] = 1'b0;
                    end
                end else if ($urandom_range(0, 99) < 3) begin
                    req_i[k] = 1'b0;
                end
            end
            arst_i = ($urandom_range(0, 1499) == 0);
        end
        arst_i = 1'b0;
        req_i  = '0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
